// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and types for the UART receive/transmit blocks
//
// Purpose: receiver state encoding, parity mode constants and the bit-counter
// width helper used by uart_rx_fifo (and the planned uart_tx_fifo).
// Ports: none (package).

package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO
//
// Purpose: small FWFT FIFO; the head entry is presented on rdata whenever the
// FIFO is not empty. A push while full is accepted only if a pop happens on
// the same clock, so a full FIFO can be read and refilled in one cycle.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   push, wdata    write request and data
//   pop            advance the head; ignored when empty
//   rdata          head entry (0 while empty)
//   full, empty    occupancy flags
//   level          number of stored entries

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [WIDTH-1:0]               wdata,
  input  logic                           pop,
  output logic [WIDTH-1:0]               rdata,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_pop;
  logic             do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = LW'(wr_ptr - rd_ptr);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: rdata is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver with FWFT receive FIFO and sticky error flags
//
// Purpose: samples an asynchronous serial line, assembles LSB-first frames with
// optional parity, pushes good characters into a receive FIFO and records
// framing, parity and overrun errors until cleared.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   re             pop the FIFO head (ignored when empty)
//   err_clr        clear all sticky error flags
//   dout           FIFO head, valid while !empty
//   empty, full    FIFO occupancy flags
//   level          FIFO entry count
//   done           one-cycle pulse per character written to the FIFO
//   frame_err      sticky: stop bit sampled low
//   parity_err     sticky: parity mismatch
//   overrun        sticky: good character dropped because the FIFO was full
//   rx             serial input, asynchronous to clk

module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1000,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int FIFO_DEPTH   = 4,
  parameter int INVERT       = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              re,
  input  logic                              err_clr,
  output logic [DATA_BITS-1:0]              dout,
  output logic                              empty,
  output logic                              full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
  output logic                              done,
  output logic                              frame_err,
  output logic                              parity_err,
  output logic                              overrun,
  input  logic                              rx
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam int IW = cnt_width(DATA_BITS);
  localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF     = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] IDX_ONE  = {{(IW-1){1'b0}}, 1'b1};

  // Input synchroniser; both flops reset to the idle (high) line level.
  logic sync1;
  logic sync2;
  logic s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
    end
  end

  assign s = (INVERT != 0) ? ~sync2 : sync2;

  rx_state_t            state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad;
  logic                 par_xor;
  logic                 par_mismatch;
  logic                 stop_sample;
  logic                 push_req;
  logic                 fifo_full;

  // XOR over data plus the parity bit currently on the line.
  assign par_xor      = ^{shreg, s};
  assign par_mismatch = (PARITY == PARITY_ODD) ? ~par_xor : par_xor;

  // The FIFO write is taken directly from the stop-sample decode so the
  // character lands on the same clock the stop bit is sampled.
  assign stop_sample = (state == ST_STOP) && (cnt == LAST);
  assign push_req    = stop_sample && s && !par_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      done       <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      done <= 1'b0;

      // Clear first so a new error on the same clock overrides it below.
      if (err_clr) begin
        frame_err  <= 1'b0;
        parity_err <= 1'b0;
        overrun    <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          cnt     <= '0;
          idx     <= '0;
          par_bad <= 1'b0;
          if (!s) state <= ST_START;
        end

        ST_START: begin
          if (cnt == HALF) begin
            cnt   <= '0;
            // A start bit that is high again at mid-bit is a glitch.
            state <= s ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        ST_DATA: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            shreg <= {s, shreg[DATA_BITS-1:1]};
            if (idx == IDX_LAST) begin
              idx   <= '0;
              state <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              idx <= idx + IDX_ONE;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        ST_PARITY: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            par_bad <= par_mismatch;
            state   <= ST_STOP;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        ST_STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (s) begin
              state <= ST_IDLE;
              if (par_bad) begin
                parity_err <= 1'b1;
              end else if (!fifo_full || re) begin
                done <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= ST_BREAK;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        // Hold here while the line stays low so a break is one error, not many.
        ST_BREAK: begin
          cnt <= '0;
          if (s) state <= ST_IDLE;
        end

        default: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .wdata (shreg),
    .pop   (re),
    .rdata (dout),
    .full  (fifo_full),
    .empty (empty),
    .level (level)
  );

  assign full = fifo_full;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo (8N1 and 8E1 instances)

module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DB    = 8;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          rx0 = 1'b1, re0 = 1'b0, clr0 = 1'b0;
  logic [DB-1:0] dout0;
  logic          empty0, full0, done0, fe0, pe0, ov0;
  logic [LW-1:0] level0;

  logic          rx1 = 1'b1, re1 = 1'b0, clr1 = 1'b0;
  logic [DB-1:0] dout1;
  logic          empty1, full1, done1, fe1, pe1, ov1;
  logic [LW-1:0] level1;

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(0), .FIFO_DEPTH(DEPTH), .INVERT(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .re(re0), .err_clr(clr0), .dout(dout0),
    .empty(empty0), .full(full0), .level(level0), .done(done0),
    .frame_err(fe0), .parity_err(pe0), .overrun(ov0), .rx(rx0)
  );

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(2), .FIFO_DEPTH(DEPTH), .INVERT(0)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .re(re1), .err_clr(clr1), .dout(dout1),
    .empty(empty1), .full(full1), .level(level1), .done(done1),
    .frame_err(fe1), .parity_err(pe1), .overrun(ov1), .rx(rx1)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // done pulses observed per instance
  int dcnt [2];
  always @(negedge clk) begin
    if (done0) dcnt[0]++;
    if (done1) dcnt[1]++;
  end

  // Reference model: expected FIFO contents, sticky flags, expected push count.
  logic [DB-1:0] q0[$];
  logic [DB-1:0] q1[$];
  bit  m_fe [2];
  bit  m_pe [2];
  bit  m_ov [2];
  int  dexp [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic line(input int sel, input logic b);
    if (sel == 0) rx0 = b; else rx1 = b;
  endtask

  function automatic int qsize(input int sel);
    return (sel == 0) ? q0.size() : q1.size();
  endfunction

  // Drive one frame; instance 1 carries an even-parity bit. After the stop bit
  // the line is held low for hold_bits bit times when the stop bit was low.
  task automatic send(input int sel, input logic [DB-1:0] d, input logic pbit,
                      input logic stopb, input int hold_bits);
    line(sel, 1'b0);
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      line(sel, d[i]);
      repeat (CPB) @(negedge clk);
    end
    if (sel == 1) begin
      line(sel, pbit);
      repeat (CPB) @(negedge clk);
    end
    line(sel, stopb);
    repeat (CPB) @(negedge clk);
    if (!stopb) repeat (hold_bits * CPB) @(negedge clk);
    line(sel, 1'b1);
    repeat (2 * CPB) @(negedge clk);

    if (!stopb) m_fe[sel] = 1'b1;
    else if (sel == 1 && pbit != ^d) m_pe[sel] = 1'b1;
    else if (qsize(sel) == DEPTH) m_ov[sel] = 1'b1;
    else begin
      if (sel == 0) q0.push_back(d); else q1.push_back(d);
      dexp[sel]++;
    end
  endtask

  task automatic pop(input int sel);
    logic [DB-1:0] tmp;
    @(negedge clk);
    if (sel == 0) re0 = 1'b1; else re1 = 1'b1;
    @(negedge clk);
    re0 = 1'b0;
    re1 = 1'b0;
    if (sel == 0 && q0.size() > 0) tmp = q0.pop_front();
    if (sel == 1 && q1.size() > 0) tmp = q1.pop_front();
  endtask

  task automatic clear_errs(input int sel);
    @(negedge clk);
    if (sel == 0) clr0 = 1'b1; else clr1 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
    clr1 = 1'b0;
    m_fe[sel] = 1'b0;
    m_pe[sel] = 1'b0;
    m_ov[sel] = 1'b0;
  endtask

  task automatic check_state(input int sel, input string tag);
    if (sel == 0) begin
      chk({tag, ".level"}, 32'(level0), 32'(q0.size()));
      chk({tag, ".empty"}, 32'(empty0), 32'(q0.size() == 0));
      chk({tag, ".full"},  32'(full0),  32'(q0.size() == DEPTH));
      if (q0.size() > 0) chk({tag, ".dout"}, 32'(dout0), 32'(q0[0]));
      chk({tag, ".frame_err"},  32'(fe0), 32'(m_fe[0]));
      chk({tag, ".parity_err"}, 32'(pe0), 32'(m_pe[0]));
      chk({tag, ".overrun"},    32'(ov0), 32'(m_ov[0]));
    end else begin
      chk({tag, ".level"}, 32'(level1), 32'(q1.size()));
      chk({tag, ".empty"}, 32'(empty1), 32'(q1.size() == 0));
      chk({tag, ".full"},  32'(full1),  32'(q1.size() == DEPTH));
      if (q1.size() > 0) chk({tag, ".dout"}, 32'(dout1), 32'(q1[0]));
      chk({tag, ".frame_err"},  32'(fe1), 32'(m_fe[1]));
      chk({tag, ".parity_err"}, 32'(pe1), 32'(m_pe[1]));
      chk({tag, ".overrun"},    32'(ov1), 32'(m_ov[1]));
    end
    chk({tag, ".done_count"}, 32'(dcnt[sel]), 32'(dexp[sel]));
  endtask

  task automatic reset_model();
    q0.delete();
    q1.delete();
    for (int i = 0; i < 2; i++) begin
      m_fe[i] = 1'b0;
      m_pe[i] = 1'b0;
      m_ov[i] = 1'b0;
      dexp[i] = dcnt[i];
    end
  endtask

  initial begin
    logic [DB-1:0] d;
    logic          pb;
    int            act;

    dcnt[0] = 0;
    dcnt[1] = 0;
    reset_model();

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset.dout", 32'(dout0), 32'h0);
    chk("reset.done", 32'(done0), 32'h0);
    check_state(0, "reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single 8N1 character
    send(0, 8'hA5, 1'b0, 1'b1, 0);
    check_state(0, "a5");
    pop(0);
    check_state(0, "a5_pop");

    // Fill past depth: fifth character overruns
    for (int i = 0; i < 5; i++) begin
      send(0, DB'(i), 1'b0, 1'b1, 0);
      check_state(0, $sformatf("fill%0d", i));
    end
    for (int i = 0; i < 4; i++) begin
      pop(0);
      check_state(0, $sformatf("drain%0d", i));
    end
    clear_errs(0);
    check_state(0, "ov_clr");

    // Even parity: correct then wrong parity bit
    send(1, 8'h03, 1'b0, 1'b1, 0);
    check_state(1, "par_ok");
    send(1, 8'h03, 1'b1, 1'b1, 0);
    check_state(1, "par_bad");
    pop(1);
    clear_errs(1);
    check_state(1, "par_clr");

    // Framing error followed by a long break, then a clean frame
    send(0, 8'h55, 1'b0, 1'b0, 40);
    check_state(0, "break");
    send(0, 8'h3C, 1'b0, 1'b1, 0);
    check_state(0, "after_break");
    pop(0);
    clear_errs(0);

    // Short low glitch while idle
    @(negedge clk);
    rx0 = 1'b0;
    repeat (3) @(negedge clk);
    rx0 = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check_state(0, "glitch");

    // Randomised traffic on both instances
    for (int n = 0; n < 14; n++) begin
      act = $urandom_range(0, 2);
      d   = DB'($urandom);
      if (act == 0 && q0.size() > 0) pop(0);
      else send(0, d, 1'b0, 1'b1, 0);
      check_state(0, $sformatf("rnd0_%0d", n));
    end
    for (int n = 0; n < 8; n++) begin
      act = $urandom_range(0, 3);
      d   = DB'($urandom);
      pb  = (act == 0) ? ~(^d) : ^d;
      if (act == 1 && q1.size() > 0) pop(1);
      else send(1, d, pb, 1'b1, 0);
      check_state(1, $sformatf("rnd1_%0d", n));
    end

    // Reset in the middle of a data bit
    @(negedge clk);
    rx0 = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx0 = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (CPB) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    reset_model();
    chk("midrst.dout", 32'(dout0), 32'h0);
    chk("midrst.done", 32'(done0), 32'h0);
    check_state(0, "midrst");
    check_state(1, "midrst1");
    @(negedge clk);
    rx0   = 1'b1;
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    send(0, 8'h7E, 1'b0, 1'b1, 0);
    check_state(0, "after_rst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Parametrised UART receiver for the SoC peripheral bus: configurable data width, optional parity, input inversion, and a receive FIFO with sticky error flags.
- Receives serial frames, buffers good characters in a first-word-fall-through FIFO, and keeps receiving while the CPU drains it.
- Replaces the single-byte receiver; the CPU polls `empty`/`level` and pops with `re`.

Parameters:
- CLKS_PER_BIT, 1000: clocks per bit period; must be >= 4.
- DATA_BITS, 8: data bits per frame, 5..9, LSB first.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- FIFO_DEPTH, 4: receive FIFO entries; power of two, >= 2.
- INVERT, 0: 1 = rx line is inverted before sampling.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- re  in  1  pop the FIFO head; ignored when empty.
- err_clr  in  1  clear all sticky error flags.
- dout  out  DATA_BITS  FIFO head; valid while !empty.
- empty  out  1  FIFO holds no entries.
- full  out  1  FIFO holds FIFO_DEPTH entries.
- level  out  $clog2(FIFO_DEPTH+1)  number of FIFO entries.
- done  out  1  one-cycle pulse when a good character is pushed.
- frame_err  out  1  sticky: a stop bit was sampled low.
- parity_err  out  1  sticky: a parity mismatch was seen.
- overrun  out  1  sticky: a good character arrived while the FIFO was full.
- rx  in  1  serial input, asynchronous to clk.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values:
  - Synchroniser flops = 1 (idle line), state = IDLE, counters = 0.
  - FIFO pointers = 0, so empty = 1, full = 0, level = 0.
  - dout = 0, done = 0, all error flags = 0.
  - Reset mid-frame abandons the frame; nothing is pushed.
- Input path: rx passes through a 2-flop synchroniser; INVERT is applied after it. All sampling uses the synchronised value `s`.
- State machine:
  - IDLE: on s == 0, go to START; bit counter = 0, index = 0.
  - START: count to (CLKS_PER_BIT-1)/2. If s == 0 there, go to DATA with counter = 0; otherwise treat as a glitch and return to IDLE.
  - DATA: on each counter == CLKS_PER_BIT-1, shift s into the MSB of the shift register (LSB-first frame) and reset the counter. After DATA_BITS samples, go to PARITY if PARITY != 0, else STOP.
  - PARITY: sample at counter == CLKS_PER_BIT-1. Record the mismatch: odd parity requires XOR(data, p) == 1, even requires == 0. Go to STOP.
  - STOP: sample at counter == CLKS_PER_BIT-1.
    - s == 1 and no parity mismatch: push the character, then IDLE.
    - s == 1 with a parity mismatch: discard, set parity_err, then IDLE.
    - s == 0: discard, set frame_err (parity_err is not also set), go to BREAK.
  - BREAK: wait until s == 1, then IDLE. This prevents a held-low line from generating repeated frames.
  - Illegal state: go to IDLE.
- Counter width: $clog2(CLKS_PER_BIT) bits; no wrap inside a bit period.
- Push:
  - Occurs on the stop-sample clock. The entry is visible on dout/level on the next cycle.
  - done pulses on the same clock as the write, for exactly 1 cycle.
  - If full and re is not asserted that cycle: drop the character, set overrun, no done pulse.
  - If full and re is asserted the same cycle: pop then push, no overrun, level unchanged.
- Pop: re && !empty advances the read pointer; dout shows the next entry on the following cycle. re while empty has no effect.
- Simultaneous push and pop when not full: level unchanged.
- Receiver never stalls; receiving continues regardless of FIFO state.
- Error flags:
  - Sticky until err_clr.
  - When err_clr and a new error occur on the same cycle, set wins.
- Latency from the rx start edge to the push: 2 synchroniser cycles + (CLKS_PER_BIT-1)/2 + (DATA_BITS + parity + 1) × CLKS_PER_BIT clocks.

Decomposition:
- Shared package `uart_pkg` holds:
  - State encodings IDLE/START/DATA/PARITY/STOP/BREAK.
  - Parity mode constants PARITY_NONE/ODD/EVEN.
  - A bit-counter width function.
- One natural sub-module: `sync_fifo` (parameters WIDTH, DEPTH; FWFT; push/pop/full/empty/level). It is reusable by the planned uart_tx_fifo.

Test Plan (CLKS_PER_BIT=16, DATA_BITS=8, FIFO_DEPTH=4 unless noted):
- Send 0xA5, 8N1 -> done pulses once; dout=0xA5, level=1, empty=0; no error flags; re -> empty=1.
- Send 0x00..0x04 with no reads -> first 4 stored in order, overrun=1 after the 5th, level=4; pop all -> 0x00,0x01,0x02,0x03; err_clr -> overrun=0.
- PARITY=2, send 0x03 with correct parity 0, then 0x03 with parity 1:
  - Correct parity -> pushed.
  - Wrong parity -> not pushed, parity_err=1, level=1.
- Send 0x55 with the stop bit driven low, then hold rx low for 40 bits, then release and send 0x3C:
  - frame_err=1; no push during the break.
  - 0x3C received correctly afterwards.
- Low glitch on rx for 3 clocks while idle -> returns to IDLE; no push, no errors.
- rst_n asserted mid-data-bit of a frame -> all outputs at reset values immediately; the next full frame 0x7E is received correctly.
